fpga_reset_seq: RTL and testbench

- Sequences SoC resets from the board PLL's lock output, in the PLL output clock domain.
- Synchronises the asynchronous `pll_locked`, requires lock to be stable, then releases the debug-module reset and, after a further delay, the system reset.
- Reasserts reset on loss of lock or on a one-cycle software/debug reset request.
- Sits between the PLL wrapper and the SoC top.

---
 rtl/fpga_reset_seq_pkg.sv | 27 ++
 rtl/fpga_reset_seq_if.sv | 38 +++
 rtl/sync_1bit.sv | 31 +++
 rtl/fpga_reset_seq.sv | 184 ++++++++++++++++++
 tb/tb_fpga_reset_seq.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/fpga_reset_seq_pkg.sv
// Purpose: shared state encoding and sizing helpers for the reset sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fpga_reset_seq_pkg;

  localparam int SEQ_STATE_W = 3;

  // Encoding is visible on the seq_state debug tap, so keep the values fixed.
  localparam logic [SEQ_STATE_W-1:0] WAIT_LOCK = 3'd0;
  localparam logic [SEQ_STATE_W-1:0] DM_HOLD   = 3'd1;
  localparam logic [SEQ_STATE_W-1:0] SYS_HOLD  = 3'd2;
  localparam logic [SEQ_STATE_W-1:0] RUN       = 3'd3;
  localparam logic [SEQ_STATE_W-1:0] SW_RST    = 3'd4;

  typedef enum logic [SEQ_STATE_W-1:0] {
    ST_WAIT_LOCK = WAIT_LOCK,
    ST_DM_HOLD   = DM_HOLD,
    ST_SYS_HOLD  = SYS_HOLD,
    ST_RUN       = RUN,
    ST_SW_RST    = SW_RST
  } seq_state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fpga_reset_seq_if.sv
// Purpose: bundles the PLL-side inputs and SoC-side reset outputs of the sequencer.
// Latency: n/a (wiring only).
// Backpressure: n/a.
// master = board/PLL side driving the requests, slave = the sequencer.
// With FPGA_RESET_SEQ_BUTTON_EN defined, btn_rst_n (async, active-low) is added.
interface fpga_reset_seq_if;

  logic                                     pll_locked;
  logic                                     sw_req_reset;
  logic                                     rst_n_dm;
  logic                                     rst_n_sys;
  logic [fpga_reset_seq_pkg::SEQ_STATE_W-1:0] seq_state;

`ifdef FPGA_RESET_SEQ_BUTTON_EN
  logic btn_rst_n;

  modport master (
    output pll_locked, sw_req_reset, btn_rst_n,
    input  rst_n_dm, rst_n_sys, seq_state
  );

  modport slave (
    input  pll_locked, sw_req_reset, btn_rst_n,
    output rst_n_dm, rst_n_sys, seq_state
  );
`else
  modport master (
    output pll_locked, sw_req_reset,
    input  rst_n_dm, rst_n_sys, seq_state
  );

  modport slave (
    input  pll_locked, sw_req_reset,
    output rst_n_dm, rst_n_sys, seq_state
  );
`endif

endinterface

// File: rtl/sync_1bit.sv
// Purpose: STAGES-flop synchroniser for one asynchronous level signal.
// Latency: STAGES clk edges from d to q.
// Backpressure: none.
// Ports: clk, rst (sync, active-high, clears chain to 0), d (async in), q (synchronised out).
module sync_1bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/fpga_reset_seq.sv
// Purpose: sequences debug-module then system reset release from PLL lock; re-asserts on lock loss / sw request.
// Latency: rst_n_dm releases LOCK_STABLE_CYCLES+DM_RELEASE_CYCLES after synchronised lock, rst_n_sys SYS_RELEASE_CYCLES later.
// Backpressure: none; sw_req_reset is a one-cycle pulse, honoured only in RUN.
// Ports: clk (PLL output clock), rst (sync, active-high), bus (slave): pll_locked, sw_req_reset in;
//        rst_n_dm, rst_n_sys (registered, active-low), seq_state (3-bit debug tap) out.
// Option FPGA_RESET_SEQ_BUTTON_EN: adds bus.btn_rst_n, debounced over DEBOUNCE_CYCLES, acting as lock loss.
module fpga_reset_seq
  import fpga_reset_seq_pkg::*;
#(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int DM_RELEASE_CYCLES  = 16,
  parameter int SYS_RELEASE_CYCLES = 16,
  parameter int SWRST_CYCLES       = 32
`ifdef FPGA_RESET_SEQ_BUTTON_EN
  ,
  parameter int DEBOUNCE_CYCLES    = 65536
`endif
) (
  input  logic              clk,
  input  logic              rst,
  fpga_reset_seq_if.slave   bus
);

  localparam int CNT_MAX = max2(max2(LOCK_STABLE_CYCLES, DM_RELEASE_CYCLES),
                                max2(SYS_RELEASE_CYCLES, SWRST_CYCLES));
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // Terminal values: each state leaves on the edge where the counter holds N-1,
  // so the state lasts exactly N cycles and the counter never exceeds its width.
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DM_LAST   = CNT_W'(DM_RELEASE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SYS_LAST  = CNT_W'(SYS_RELEASE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SW_LAST   = CNT_W'(SWRST_CYCLES - 1);

  logic       locked_s;
  logic       abort;

  seq_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic       rst_n_dm_q, rst_n_dm_d;
  logic       rst_n_sys_q, rst_n_sys_d;

  sync_1bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.pll_locked),
    .q   (locked_s)
  );

`ifdef FPGA_RESET_SEQ_BUTTON_EN
  localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DEB_W-1:0] DEB_MAX  = DEB_W'(DEBOUNCE_CYCLES);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

  logic             btn_s;
  logic             btn_press;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;

  sync_1bit #(.STAGES(SYNC_STAGES)) u_btn_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.btn_rst_n),
    .q   (btn_s)
  );

  // deb_cnt_q counts previous consecutive low samples (saturating); the press
  // is accepted on the edge that takes the DEBOUNCE_CYCLES-th low sample and
  // holds for as long as the button stays low.
  always_comb begin
    deb_cnt_d = deb_cnt_q;
    btn_press = 1'b0;
    if (btn_s) begin
      deb_cnt_d = '0;
    end else begin
      btn_press = (deb_cnt_q >= DEB_LAST);
      if (deb_cnt_q != DEB_MAX) begin
        deb_cnt_d = deb_cnt_q + DEB_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      deb_cnt_q <= '0;
    end else begin
      deb_cnt_q <= deb_cnt_d;
    end
  end

  assign abort = !locked_s || btn_press;
`else
  assign abort = !locked_s;
`endif

  // Next-state / output logic. Lock loss (and an accepted button press) wins
  // over every other transition, including a same-cycle sw_req_reset.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    rst_n_dm_d  = rst_n_dm_q;
    rst_n_sys_d = rst_n_sys_q;

    if (abort) begin
      state_d     = ST_WAIT_LOCK;
      cnt_d       = '0;
      rst_n_dm_d  = 1'b0;
      rst_n_sys_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_WAIT_LOCK: begin
          rst_n_dm_d  = 1'b0;
          rst_n_sys_d = 1'b0;
          if (cnt_q == LOCK_LAST) begin
            state_d = ST_DM_HOLD;
            cnt_d   = '0;
          end
        end
        ST_DM_HOLD: begin
          rst_n_dm_d  = 1'b0;
          rst_n_sys_d = 1'b0;
          if (cnt_q == DM_LAST) begin
            state_d    = ST_SYS_HOLD;
            cnt_d      = '0;
            rst_n_dm_d = 1'b1;
          end
        end
        ST_SYS_HOLD: begin
          rst_n_dm_d  = 1'b1;
          rst_n_sys_d = 1'b0;
          if (cnt_q == SYS_LAST) begin
            state_d     = ST_RUN;
            cnt_d       = '0;
            rst_n_sys_d = 1'b1;
          end
        end
        ST_RUN: begin
          // Counter parked at 0 so it cannot run away while idling here.
          cnt_d       = '0;
          rst_n_dm_d  = 1'b1;
          rst_n_sys_d = 1'b1;
          if (bus.sw_req_reset) begin
            state_d     = ST_SW_RST;
            rst_n_sys_d = 1'b0;
          end
        end
        ST_SW_RST: begin
          // Further requests are not looked at here, so they cannot extend the hold.
          rst_n_dm_d  = 1'b1;
          rst_n_sys_d = 1'b0;
          if (cnt_q == SW_LAST) begin
            state_d = ST_SYS_HOLD;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d     = ST_WAIT_LOCK;
          cnt_d       = '0;
          rst_n_dm_d  = 1'b0;
          rst_n_sys_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_WAIT_LOCK;
      cnt_q       <= '0;
      rst_n_dm_q  <= 1'b0;
      rst_n_sys_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rst_n_dm_q  <= rst_n_dm_d;
      rst_n_sys_q <= rst_n_sys_d;
    end
  end

  assign bus.rst_n_dm  = rst_n_dm_q;
  assign bus.rst_n_sys = rst_n_sys_q;
  assign bus.seq_state = state_q;

endmodule

// File: tb/tb_fpga_reset_seq.sv
// Purpose: self-checking bench for fpga_reset_seq (directed table, button sequence, random run vs. run-length model).
// Latency: n/a.
// Backpressure: n/a.
module tb_fpga_reset_seq;

  localparam int SYNC = 2;
  localparam int L    = 8;
  localparam int D    = 4;
  localparam int S    = 4;
  localparam int SW   = 6;
  localparam int DEB  = 5;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fpga_reset_seq_if bus ();

  fpga_reset_seq #(
    .SYNC_STAGES        (SYNC),
    .LOCK_STABLE_CYCLES (L),
    .DM_RELEASE_CYCLES  (D),
    .SYS_RELEASE_CYCLES (S),
    .SWRST_CYCLES       (SW)
`ifdef FPGA_RESET_SEQ_BUTTON_EN
    ,
    .DEBOUNCE_CYCLES    (DEB)
`endif
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: everything is derived from how long the (effective)
  // synchronised lock has been continuously high, and how long ago a
  // software reset was accepted.
  int run       = 0;   // consecutive edges that sampled effective lock high
  int edge_idx  = 0;
  int sw_edge   = 0;
  bit sw_active = 0;
  int low_run   = 0;   // consecutive low synchronised button samples
  bit lk_pipe[SYNC];
  bit bt_pipe[SYNC];
  bit m_dm  = 0;
  bit m_sys = 0;
  int m_st  = 0;

  function automatic void model_eval();
    int d;
    m_dm  = (run >= L + D);
    m_sys = (run >= L + D + S);
    if (run < L)              m_st = 0;
    else if (run < L + D)     m_st = 1;
    else if (run < L + D + S) m_st = 2;
    else                      m_st = 3;
    if (sw_active && m_sys) begin
      d = edge_idx - sw_edge;
      if (d < SW) begin
        m_sys = 0;
        m_st  = 4;
      end else if (d < SW + S) begin
        m_sys = 0;
        m_st  = 2;
      end
    end
  endfunction

  function automatic void model_edge(input bit r, input bit p, input bit s, input bit b);
    bit ls, bs, acc, in_run;
    edge_idx++;
    if (r) begin
      run = 0;
      sw_active = 0;
      low_run = 0;
      for (int i = 0; i < SYNC; i++) begin
        lk_pipe[i] = 0;
        bt_pipe[i] = 0;
      end
    end else begin
      ls = lk_pipe[SYNC-1];
      bs = bt_pipe[SYNC-1];
      low_run = bs ? 0 : low_run + 1;
      acc = 0;
`ifdef FPGA_RESET_SEQ_BUTTON_EN
      acc = (low_run >= DEB);
`endif
      in_run = (m_st == 3);
      if (ls && !acc) begin
        run++;
        if (in_run && s) begin
          sw_active = 1;
          sw_edge = edge_idx;
        end
      end else begin
        run = 0;
        sw_active = 0;
      end
      for (int i = SYNC - 1; i > 0; i--) begin
        lk_pipe[i] = lk_pipe[i-1];
        bt_pipe[i] = bt_pipe[i-1];
      end
      lk_pipe[0] = p;
      bt_pipe[0] = b;
    end
    model_eval();
  endfunction

  // One clock: drive inputs, take the edge, update model, compare 1 ns later.
  task automatic step(input bit r, input bit p, input bit s, input bit b);
    rst = r;
    bus.pll_locked = p;
    bus.sw_req_reset = s;
`ifdef FPGA_RESET_SEQ_BUTTON_EN
    bus.btn_rst_n = b;
`endif
    @(posedge clk);
    model_edge(r, p, s, b);
    #1;
    checks++;
    if ({bus.rst_n_dm, bus.rst_n_sys, bus.seq_state} !== {m_dm, m_sys, 3'(m_st)}) begin
      errors++;
      $display("FAIL model edge %0d: dm/sys/state got %b/%b/%0d expected %b/%b/%0d",
               edge_idx, bus.rst_n_dm, bus.rst_n_sys, bus.seq_state, m_dm, m_sys, m_st);
    end
  endtask

  task automatic expect_out(input string name, input bit dm, input bit sys, input int st);
    checks++;
    if ({bus.rst_n_dm, bus.rst_n_sys, bus.seq_state} !== {dm, sys, 3'(st)}) begin
      errors++;
      $display("FAIL %s: dm/sys/state got %b/%b/%0d expected %b/%b/%0d",
               name, bus.rst_n_dm, bus.rst_n_sys, bus.seq_state, dm, sys, st);
    end
  endtask

  typedef struct {
    bit r;
    bit p;
    bit s;
    int n;
    bit dm;
    bit sys;
    int st;
  } vec_t;

  vec_t vecs[27];

  initial begin
    for (int i = 0; i < SYNC; i++) begin
      lk_pipe[i] = 0;
      bt_pipe[i] = 0;
    end

    //          r  p  s   n  dm sys st
    vecs[0]  = '{1, 1, 0,  3, 0, 0, 0};  // held in reset
    vecs[1]  = '{0, 1, 0,  9, 0, 0, 0};  // count 7 of 8
    vecs[2]  = '{0, 1, 0,  1, 0, 0, 1};  // lock stable -> DM_HOLD
    vecs[3]  = '{0, 1, 0,  3, 0, 0, 1};
    vecs[4]  = '{0, 1, 0,  1, 1, 0, 2};  // dm release at k+12
    vecs[5]  = '{0, 1, 0,  3, 1, 0, 2};
    vecs[6]  = '{0, 1, 0,  1, 1, 1, 3};  // sys release at k+16
    vecs[7]  = '{0, 1, 1,  1, 1, 0, 4};  // sw request accepted
    vecs[8]  = '{0, 1, 1,  3, 1, 0, 4};  // repeats ignored
    vecs[9]  = '{0, 1, 0,  2, 1, 0, 4};
    vecs[10] = '{0, 1, 0,  1, 1, 0, 2};  // SW_RST -> SYS_HOLD after 6
    vecs[11] = '{0, 1, 0,  3, 1, 0, 2};
    vecs[12] = '{0, 1, 0,  1, 1, 1, 3};  // sys low for exactly 10
    vecs[13] = '{0, 0, 0,  2, 1, 1, 3};  // lock drop still in synchroniser
    vecs[14] = '{0, 0, 1,  1, 0, 0, 0};  // lock loss beats sw request
    vecs[15] = '{0, 1, 0,  7, 0, 0, 0};
    vecs[16] = '{0, 0, 0,  1, 0, 0, 0};  // one-cycle glitch
    vecs[17] = '{0, 1, 0,  2, 0, 0, 0};  // glitch restarts count
    vecs[18] = '{0, 1, 0,  7, 0, 0, 0};
    vecs[19] = '{0, 1, 0,  1, 0, 0, 1};
    vecs[20] = '{0, 1, 0,  3, 0, 0, 1};
    vecs[21] = '{0, 1, 0,  1, 1, 0, 2};  // in SYS_HOLD
    vecs[22] = '{1, 1, 0,  1, 0, 0, 0};  // rst mid-sequence
    vecs[23] = '{0, 1, 0, 12, 0, 0, 1};  // replay
    vecs[24] = '{0, 1, 0,  2, 1, 0, 2};
    vecs[25] = '{0, 1, 0,  3, 1, 0, 2};
    vecs[26] = '{0, 1, 0,  1, 1, 1, 3};

    for (int v = 0; v < 27; v++) begin
      for (int c = 0; c < vecs[v].n; c++) begin
        step(vecs[v].r, vecs[v].p, vecs[v].s, 1'b1);
      end
      expect_out($sformatf("vec%0d", v), vecs[v].dm, vecs[v].sys, vecs[v].st);
    end

`ifdef FPGA_RESET_SEQ_BUTTON_EN
    // Short press (4 low samples) is filtered out.
    for (int c = 0; c < 4; c++) step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) step(1'b0, 1'b1, 1'b0, 1'b1);
    expect_out("btn_short", 1'b1, 1'b1, 3);
    // Long press: 2 sync edges + 5 low samples.
    for (int c = 0; c < 6; c++) step(1'b0, 1'b1, 1'b0, 1'b0);
    expect_out("btn_pre_accept", 1'b1, 1'b1, 3);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    expect_out("btn_accept", 1'b0, 1'b0, 0);
    for (int c = 0; c < 10; c++) step(1'b0, 1'b1, 1'b0, 1'b0);
    expect_out("btn_held", 1'b0, 1'b0, 0);
    // Release: dm rises 2+8+4 edges later.
    for (int c = 0; c < 13; c++) step(1'b0, 1'b1, 1'b0, 1'b1);
    expect_out("btn_release_pre", 1'b0, 1'b0, 1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    expect_out("btn_release_dm", 1'b1, 1'b0, 2);
`endif

    // Randomised run: alternate noisy and quiet lock phases, rare rst and sw requests.
    for (int i = 0; i < 3000; i++) begin
      bit r, p, s, b;
      r = ($urandom_range(0, 599) == 0);
      p = ($urandom_range(0, ((i % 1000) < 400) ? 15 : 250) != 0);
      s = ($urandom_range(0, 19) == 0);
      b = 1'b1;
`ifdef FPGA_RESET_SEQ_BUTTON_EN
      b = ((i % 300) < 280) ? 1'b1 : ($urandom_range(0, 7) != 0 ? 1'b0 : 1'b1);
`endif
      step(r, p, s, b);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
